test_vector_loader: RTL and testbench
=====================================

# test_vector_loader

Front-end stage that feeds the neural network datapath. It accepts one test sample as a byte stream over a valid/ready handshake: 62 feature bytes followed by one expected-label byte. It assembles the features into the 496-bit `test_data` vector and pulses `nn_start`. It then waits for the datapath's `ready` and captures the classified digit (`test_out`). Finally it scores the result against the label and keeps running sample/correct counters for the testbench or host.

## Interface

Parameters:
- `DW`, 8: feature/label byte width.
- `N`, 62: features per sample; `test_data` width is N*DW.
- `TIMEOUT`, 4096: maximum WAIT cycles before a sample is reported as timed out.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous clear of counters.
- `in_valid` in 1: stream byte valid.
- `in_data` in DW: stream byte.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `test_data` out N*DW: feature k at bits [k*DW +: DW]; drives datapath `test_data`.
- `nn_start` out 1: one-cycle start pulse to the datapath controller.
- `nn_ready` in 1: datapath `ready`.
- `nn_class` in 8: datapath `test_out`.
- `result_valid` out 1: one-cycle pulse per finished sample.
- `result_class` out 8: captured `nn_class`.
- `result_correct` out 1: `result_class == label`, forced 0 on timeout.
- `result_timeout` out 1: sample ended by watchdog.
- `sample_count` out 16: samples reported; saturating.
- `correct_count` out 16: correct samples; saturating.

## Operation

- States: LOAD, START, WAIT, REPORT. Reset state is LOAD.
- **LOAD**
  - `in_ready`=1. A 7-bit index `idx` runs from 0 to N.
  - On handshake with idx<N: write `in_data` into feature slot idx, then idx+1.
  - On handshake with idx==N: the byte goes to the `label` register, idx←0, next state START.
- **START**
  - `nn_start`=1 for exactly this cycle; `in_ready`=0; next state WAIT.
  - The watchdog counter is cleared, and `prev_ready` is loaded with `nn_ready`.
- **WAIT**
  - `in_ready`=0. `prev_ready`←`nn_ready` every cycle.
  - Completion condition: `nn_ready && !prev_ready`, i.e. a rising edge. A level left high from the previous sample is ignored.
  - On completion: `result_class`←`nn_class`, `result_correct`←(`nn_class`=={0,`label`} truncated/extended to 8 bits), `result_timeout`←0. Next state REPORT.
  - Watchdog: increments every WAIT cycle. If it reaches TIMEOUT-1 without completion: `result_timeout`←1, `result_correct`←0, `result_class`←8'hFF, next state REPORT.
- **REPORT**
  - `result_valid`=1 for one cycle; `in_ready`=0; next state LOAD.
- **Counters**
  - Updated on the clock edge entering REPORT, so new values are visible in the same cycle as `result_valid`.
  - `sample_count`+1 always. `correct_count`+1 if `result_correct`.
  - Both saturate at 16'hFFFF.
- **`clear`**
  - Zeroes both counters in any state and does not disturb the FSM, buffer or idx.
  - If `clear` coincides with the REPORT-entry edge, clear wins: counters read 0 and that sample is not counted.
- **Data stability**: `test_data` and `label` are written only in LOAD. They are therefore stable from START through REPORT.
- **`result_*` hold**: `result_class`, `result_correct` and `result_timeout` hold their values until the next sample's completion.

## Timing

- Reset values:
  - State LOAD, idx 0, `in_ready` 1.
  - `test_data` 0, label 0.
  - `nn_start` 0, `result_valid` 0.
  - `result_class` 0, `result_correct` 0, `result_timeout` 0.
  - Both counters 0, `prev_ready` 0.
- Reset asserted mid-sample aborts immediately and returns to the reset values. A partial sample is discarded.
- Input throughput is 1 byte/cycle in LOAD, so a back-to-back sample takes N+1 cycles.
- Label accepted at edge t: `nn_start` high in cycle t+1, WAIT from t+2.
- First `nn_ready` rising edge sampled at edge r: `result_valid` high in cycle r+1, LOAD (`in_ready`=1) in cycle r+2.
- Minimum sample turnaround: N+1 load cycles + START + ≥1 WAIT + REPORT.
- `in_valid` with `in_ready`=0 has no effect. The source must hold its byte.
- `nn_start` is never asserted while in WAIT; a new start comes only after REPORT.

## Test plan

- **Reset**: assert `rst`=0 mid-LOAD after 30 bytes, then release and stream a full 63-byte sample. Expect `test_data` to equal only the new bytes, exactly one `nn_start` pulse, and counters 0 before the report.
- **Correct sample**: features k=0..61 = k+1, label 3. Model holds `nn_ready` low for 20 cycles after start, then raises it with `nn_class`=3. Expect `test_data[7:0]`=1, `test_data[495:488]`=62, `result_valid` 1 cycle after the edge, `result_correct`=1, `sample_count`=1, `correct_count`=1.
- **Wrong sample + stale ready**: `nn_ready` held high through START, drops for 1 cycle, rises with `nn_class`=7, label 2. Expect completion only on the rise, `result_correct`=0, `sample_count`=2, `correct_count` unchanged.
- **Timeout**: TIMEOUT=16 and `nn_ready` kept low. Expect `result_timeout`=1, `result_class`=8'hFF, `result_correct`=0 exactly 16 cycles after WAIT entry, then `in_ready`=1.
- **Backpressure**: drive `in_valid` during START/WAIT/REPORT. Expect no buffer or idx change; gapped `in_valid` in LOAD still assembles the correct vector.
- **Clear/saturation**: force counters to FFFF and report a correct sample. Expect both to stay FFFF. Pulse `clear` on the REPORT-entry edge. Expect both counters 0.

Source files
------------

// File: rtl/test_vector_loader.sv
// test_vector_loader
// Front-end stage for the neural network datapath. Collects one sample as a
// byte stream (N feature bytes, then one label byte), presents the assembled
// feature vector on test_data, pulses nn_start, waits for a rising edge on
// nn_ready, scores the captured class against the label and keeps saturating
// sample/correct counters.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   clear          synchronous clear of both counters (any state)
//   in_valid/in_data/in_ready   byte stream handshake (accepted in LOAD only)
//   test_data      feature k at bits [k*DW +: DW]
//   nn_start       one-cycle start pulse to the datapath
//   nn_ready       datapath done level (completion on its rising edge)
//   nn_class       datapath classification result
//   result_valid   one-cycle pulse per finished sample
//   result_class   captured nn_class (8'hFF on timeout)
//   result_correct class matched label (0 on timeout)
//   result_timeout sample ended by the watchdog
//   sample_count   samples reported, saturating
//   correct_count  correct samples, saturating
module test_vector_loader #(
    parameter int DW      = 8,
    parameter int N       = 62,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic [N*DW-1:0] test_data,
    output logic            nn_start,
    input  logic            nn_ready,
    input  logic [7:0]      nn_class,
    output logic            result_valid,
    output logic [7:0]      result_class,
    output logic            result_correct,
    output logic            result_timeout,
    output logic [15:0]     sample_count,
    output logic [15:0]     correct_count
);

    localparam int             WDW      = $clog2(TIMEOUT + 1);
    localparam logic [6:0]     IDX_LAST = 7'(N);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {LOAD, START, WAIT, REPORT} state_t;

    state_t          state_r, state_next_s;
    logic [6:0]      idx_r;
    logic [N*DW-1:0] test_data_r;
    logic [DW-1:0]   label_r;
    logic [7:0]      label8_s;
    logic            prev_ready_r;
    logic [WDW-1:0]  wd_r;
    logic            in_ready_r, nn_start_r, result_valid_r;
    logic [7:0]      res_class_r, res_class_next_s;
    logic            res_correct_r, res_correct_next_s;
    logic            res_timeout_r, res_timeout_next_s;
    logic [15:0]     sample_cnt_r, correct_cnt_r;
    logic            accept_s, done_s, tmo_s, enter_report_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign accept_s       = in_valid && (state_r == LOAD);
    assign done_s         = nn_ready && !prev_ready_r;
    assign tmo_s          = (wd_r == WD_LAST);
    assign enter_report_s = (state_r == WAIT) && (done_s || tmo_s);
    assign label8_s       = 8'(label_r);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; completion takes priority over a same-cycle timeout
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LOAD: begin
                if (accept_s && (idx_r == IDX_LAST)) begin
                    state_next_s = START;
                end else begin
                    state_next_s = LOAD;
                end
            end
            START:  state_next_s = WAIT;
            WAIT: begin
                if (done_s || tmo_s) begin
                    state_next_s = REPORT;
                end else begin
                    state_next_s = WAIT;
                end
            end
            REPORT: state_next_s = LOAD;
            default: state_next_s = LOAD;
        endcase
    end

    // Next values of the held result fields
    always_comb begin
        res_class_next_s   = res_class_r;
        res_correct_next_s = res_correct_r;
        res_timeout_next_s = res_timeout_r;
        case (state_r)
            WAIT: begin
                if (done_s) begin
                    res_class_next_s   = nn_class;
                    res_correct_next_s = (nn_class == label8_s);
                    res_timeout_next_s = 1'b0;
                end else if (tmo_s) begin
                    res_class_next_s   = 8'hFF;
                    res_correct_next_s = 1'b0;
                    res_timeout_next_s = 1'b1;
                end else begin
                    res_class_next_s   = res_class_r;
                    res_correct_next_s = res_correct_r;
                    res_timeout_next_s = res_timeout_r;
                end
            end
            default: begin
                res_class_next_s   = res_class_r;
                res_correct_next_s = res_correct_r;
                res_timeout_next_s = res_timeout_r;
            end
        endcase
    end

    // Registered handshake/strobe outputs, decoded from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r     <= 1'b1;
            nn_start_r     <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            in_ready_r     <= (state_next_s == LOAD);
            nn_start_r     <= (state_next_s == START);
            result_valid_r <= (state_next_s == REPORT);
        end
    end

    // Feature buffer, label and byte index; only written by LOAD handshakes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r       <= 7'd0;
            test_data_r <= '0;
            label_r     <= '0;
        end else if (accept_s) begin
            if (idx_r == IDX_LAST) begin
                label_r <= in_data;
                idx_r   <= 7'd0;
            end else begin
                test_data_r[int'(idx_r) * DW +: DW] <= in_data;
                idx_r <= idx_r + 7'd1;
            end
        end
    end

    // nn_ready edge detector and watchdog; prev_ready is primed in START so a
    // level left high from the previous sample does not count as completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_ready_r <= 1'b0;
            wd_r         <= '0;
        end else if (state_r == START) begin
            prev_ready_r <= nn_ready;
            wd_r         <= '0;
        end else if (state_r == WAIT) begin
            prev_ready_r <= nn_ready;
            wd_r         <= wd_r + {{(WDW-1){1'b0}}, 1'b1};
        end
    end

    // Result fields hold until the next completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_class_r   <= 8'd0;
            res_correct_r <= 1'b0;
            res_timeout_r <= 1'b0;
        end else begin
            res_class_r   <= res_class_next_s;
            res_correct_r <= res_correct_next_s;
            res_timeout_r <= res_timeout_next_s;
        end
    end

    // Saturating counters; clear beats a coincident report
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt_r  <= 16'd0;
            correct_cnt_r <= 16'd0;
        end else if (clear) begin
            sample_cnt_r  <= 16'd0;
            correct_cnt_r <= 16'd0;
        end else if (enter_report_s) begin
            sample_cnt_r <= sat_inc(sample_cnt_r);
            if (res_correct_next_s) begin
                correct_cnt_r <= sat_inc(correct_cnt_r);
            end
        end
    end

    assign in_ready       = in_ready_r;
    assign test_data      = test_data_r;
    assign nn_start       = nn_start_r;
    assign result_valid   = result_valid_r;
    assign result_class   = res_class_r;
    assign result_correct = res_correct_r;
    assign result_timeout = res_timeout_r;
    assign sample_count   = sample_cnt_r;
    assign correct_count  = correct_cnt_r;

endmodule

// File: tb/tb_test_vector_loader.sv
// Scoreboard bench for test_vector_loader. Stimulus pushes the expected
// report of each sample into a queue; a monitor pops and compares whenever
// result_valid is seen. A second instance with a short watchdog covers the
// timeout path.
module tb_test_vector_loader;

    localparam int DW = 8;
    localparam int N  = 62;
    localparam int W  = N * DW;

    logic          clk = 1'b0;
    logic          rst, clear;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [W-1:0]  test_data;
    logic          nn_start, nn_ready;
    logic [7:0]    nn_class;
    logic          result_valid, result_correct, result_timeout;
    logic [7:0]    result_class;
    logic [15:0]   sample_count, correct_count;

    logic          in_valid_b;
    logic [7:0]    in_data_b;
    logic          in_ready_b, nn_start_b, result_valid_b;
    logic [W-1:0]  test_data_b;
    logic          nn_ready_b;
    logic [7:0]    nn_class_b, result_class_b;
    logic          result_correct_b, result_timeout_b;
    logic [15:0]   sample_count_b, correct_count_b;

    typedef struct {
        logic [7:0]   cls;
        logic         cor;
        logic         tmo;
        logic [15:0]  sc;
        logic [15:0]  cc;
        logic [W-1:0] td;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] feat [N];
    int         total = 0;
    int         bad = 0;
    int         start_cnt = 0;

    always #5 clk = ~clk;

    test_vector_loader dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .test_data(test_data), .nn_start(nn_start),
        .nn_ready(nn_ready), .nn_class(nn_class),
        .result_valid(result_valid), .result_class(result_class),
        .result_correct(result_correct), .result_timeout(result_timeout),
        .sample_count(sample_count), .correct_count(correct_count)
    );

    test_vector_loader #(.TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .clear(1'b0),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .test_data(test_data_b), .nn_start(nn_start_b),
        .nn_ready(nn_ready_b), .nn_class(nn_class_b),
        .result_valid(result_valid_b), .result_class(result_class_b),
        .result_correct(result_correct_b), .result_timeout(result_timeout_b),
        .sample_count(sample_count_b), .correct_count(correct_count_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_td(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_feat();
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*8 +: 8] = feat[k];
        return v;
    endfunction

    // Monitor: count start pulses, compare every report against the queue
    always @(negedge clk) begin
        if (rst && nn_start) start_cnt++;
        if (rst && result_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got class %0h expected no report", result_class);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result_class", 64'(result_class), 64'(mon_e.cls));
                chk("result_correct", 64'(result_correct), 64'(mon_e.cor));
                chk("result_timeout", 64'(result_timeout), 64'(mon_e.tmo));
                chk("sample_count", 64'(sample_count), 64'(mon_e.sc));
                chk("correct_count", 64'(correct_count), 64'(mon_e.cc));
                chk_td("test_data", test_data, mon_e.td);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("send_byte_wait", 64'(in_ready), 64'h1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_sample(input int gap_every, input logic [7:0] lbl);
        for (int k = 0; k < N; k++) begin
            send_byte(feat[k]);
            if (gap_every > 0 && (k % gap_every) == 0) @(negedge clk);
        end
        send_byte(lbl);
    endtask

    // Full sample: load, check start, model datapath, check report timing
    task automatic do_sample(input int gap_every, input logic [7:0] lbl,
                             input int pre_high, input int low, input logic [7:0] cls,
                             input logic clr, input logic junk,
                             input logic [15:0] sc, input logic [15:0] cc);
        exp_t e;
        int   base;
        base = start_cnt;
        send_sample(gap_every, lbl);
        chk("start_pulse", 64'(nn_start), 64'h1);
        e.cls = cls;
        e.cor = (cls == lbl);
        e.tmo = 1'b0;
        e.sc  = sc;
        e.cc  = cc;
        e.td  = pack_feat();
        exp_q.push_back(e);
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 8'hEE;
        end
        if (pre_high > 0) begin
            nn_ready = 1'b1;
            repeat (pre_high) @(negedge clk);
        end
        nn_ready = 1'b0;
        repeat (low) @(negedge clk);
        nn_ready = 1'b1;
        nn_class = cls;
        in_valid = 1'b0;
        clear    = clr;
        @(negedge clk);
        clear = 1'b0;
        chk("rv_timing", 64'(result_valid), 64'h1);
        @(negedge clk);
        chk("load_return", 64'(in_ready), 64'h1);
        chk("rv_one_cycle", 64'(result_valid), 64'h0);
        chk("start_once", 64'(start_cnt - base), 64'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        nn_ready = 1'b0; nn_class = 8'h00;
        in_valid_b = 1'b0; in_data_b = 8'h00; nn_ready_b = 1'b0; nn_class_b = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_nn_start", 64'(nn_start), 64'h0);
        chk("rst_result_valid", 64'(result_valid), 64'h0);
        chk("rst_result_class", 64'(result_class), 64'h0);
        chk("rst_result_correct", 64'(result_correct), 64'h0);
        chk("rst_result_timeout", 64'(result_timeout), 64'h0);
        chk("rst_sample_count", 64'(sample_count), 64'h0);
        chk("rst_correct_count", 64'(correct_count), 64'h0);
        chk_td("rst_test_data", test_data, '0);
        rst = 1'b1;
        @(negedge clk);

        // Partial sample aborted by reset
        for (int k = 0; k < 30; k++) send_byte(8'hA0 + 8'(k));
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'h1);
        chk_td("midrst_test_data", test_data, '0);
        rst = 1'b1;
        @(negedge clk);

        // Sample 1: correct, ready rises 20 cycles after start
        for (int k = 0; k < N; k++) feat[k] = 8'(k + 1);
        send_sample(0, 8'd3);
        chk("s1_start", 64'(nn_start), 64'h1);
        chk("s1_pre_sample_count", 64'(sample_count), 64'h0);
        chk("s1_pre_correct_count", 64'(correct_count), 64'h0);
        begin
            exp_t e;
            e.cls = 8'd3; e.cor = 1'b1; e.tmo = 1'b0;
            e.sc = 16'd1; e.cc = 16'd1; e.td = pack_feat();
            exp_q.push_back(e);
        end
        nn_ready = 1'b0;
        repeat (20) @(negedge clk);
        nn_ready = 1'b1;
        nn_class = 8'd3;
        @(negedge clk);
        chk("s1_rv_timing", 64'(result_valid), 64'h1);
        @(negedge clk);
        chk("s1_load_return", 64'(in_ready), 64'h1);
        chk("s1_feat0", 64'(test_data[7:0]), 64'd1);
        chk("s1_feat61", 64'(test_data[495:488]), 64'd62);

        // Sample 2: stale ready high, junk bytes during START/WAIT, wrong class
        for (int k = 0; k < N; k++) feat[k] = 8'(255 - k);
        do_sample(0, 8'd2, 3, 1, 8'd7, 1'b0, 1'b1, 16'd2, 16'd1);

        // Sample 3: gapped input, minimum WAIT
        for (int k = 0; k < N; k++) feat[k] = 8'(k * 7 + 5);
        do_sample(3, 8'd9, 0, 1, 8'd9, 1'b0, 1'b0, 16'd3, 16'd2);

        // Sample 4: counters forced to saturation
        force dut.sample_cnt_r = 16'hFFFF;
        force dut.correct_cnt_r = 16'hFFFF;
        @(negedge clk);
        release dut.sample_cnt_r;
        release dut.correct_cnt_r;
        @(negedge clk);
        chk("forced_sample_count", 64'(sample_count), 64'hFFFF);
        for (int k = 0; k < N; k++) feat[k] = 8'(k) ^ 8'h5A;
        do_sample(0, 8'd5, 0, 4, 8'd5, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);

        // Sample 5: clear on the report-entry edge wins
        for (int k = 0; k < N; k++) feat[k] = 8'(k * 3);
        do_sample(0, 8'd1, 0, 2, 8'd1, 1'b1, 1'b0, 16'd0, 16'd0);

        // Watchdog instance: nn_ready_b never rises
        for (int k = 0; k <= N; k++) begin
            in_valid_b = 1'b1;
            in_data_b  = 8'(k);
            @(negedge clk);
        end
        in_valid_b = 1'b0;
        chk("tmo_start", 64'(nn_start_b), 64'h1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("tmo_not_early", 64'(result_valid_b), 64'h0);
        end
        @(negedge clk);
        chk("tmo_valid", 64'(result_valid_b), 64'h1);
        chk("tmo_flag", 64'(result_timeout_b), 64'h1);
        chk("tmo_class", 64'(result_class_b), 64'hFF);
        chk("tmo_correct", 64'(result_correct_b), 64'h0);
        chk("tmo_sample_count", 64'(sample_count_b), 64'h1);
        chk("tmo_correct_count", 64'(correct_count_b), 64'h0);
        @(negedge clk);
        chk("tmo_load_return", 64'(in_ready_b), 64'h1);

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
